// File: rtl/alu_result_checker.sv
// Response checker for the 8-bit ALU: golden model, two-stage compare,
// saturating pass/fail/illegal counters, opcode coverage and first-fail capture.
module alu_result_checker #(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 16,
  parameter bit HALT_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_sel,
  input  logic [WIDTH-1:0] in_c,
  output logic             chk_valid,
  output logic             chk_fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [15:0]      ops_seen,
  output logic             first_valid,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [WIDTH-1:0] first_c,
  output logic [WIDTH-1:0] first_exp,
  output logic [3:0]       first_sel,
  output logic             halted
);

  function automatic logic [WIDTH-1:0] golden(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [3:0]       sel
  );
    logic [WIDTH-1:0] r;
    case (sel)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = WIDTH'(a == b);
      4'd6:    r = a << 1;
      4'd7:    r = b << 1;
      4'd8:    r = a >> 1;
      4'd9:    r = b >> 1;
      4'd10:   r = WIDTH'(a > b);
      4'd11:   r = WIDTH'(a < b);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic             rdy_en_q;
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d, s1_exp_q, s1_exp_d;
  logic [3:0]       s1_sel_q, s1_sel_d;
  logic             chk_valid_q, chk_valid_d, chk_fail_q, chk_fail_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, ill_q, ill_d;
  logic [15:0]      ops_q, ops_d;
  logic             fv_q, fv_d, halted_q, halted_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d, fc_q, fc_d, fe_q, fe_d;
  logic [3:0]       fs_q, fs_d;
  logic             accept, mism;

  // ready is held low through reset and rises on the first edge after it
  assign in_ready = rdy_en_q && !halted_q && !clear;
  assign accept   = in_valid && in_ready;
  assign mism     = s1_c_q != s1_exp_q;

  always_comb begin
    s1_vld_d    = accept;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_c_d      = s1_c_q;
    s1_sel_d    = s1_sel_q;
    s1_exp_d    = s1_exp_q;
    chk_valid_d = 1'b0;
    chk_fail_d  = 1'b0;
    pass_d      = pass_q;
    fail_d      = fail_q;
    ill_d       = ill_q;
    ops_d       = ops_q;
    fv_d        = fv_q;
    fa_d        = fa_q;
    fb_d        = fb_q;
    fc_d        = fc_q;
    fe_d        = fe_q;
    fs_d        = fs_q;
    halted_d    = halted_q;
    if (accept) begin
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_c_d   = in_c;
      s1_sel_d = in_sel;
      s1_exp_d = golden(in_a, in_b, in_sel);
    end
    if (s1_vld_q) begin
      chk_valid_d     = 1'b1;
      chk_fail_d      = mism;
      ops_d[s1_sel_q] = 1'b1;
      if (s1_sel_q[3:2] == 2'b11) ill_d = sat_inc(ill_q);
      if (mism) fail_d = sat_inc(fail_q);
      else      pass_d = sat_inc(pass_q);
      if (mism && !fv_q) begin
        fv_d = 1'b1;
        fa_d = s1_a_q;
        fb_d = s1_b_q;
        fc_d = s1_c_q;
        fe_d = s1_exp_q;
        fs_d = s1_sel_q;
      end
      if (mism && HALT_ON_FAIL) halted_d = 1'b1;
    end
    if (clear) begin
      s1_vld_d    = 1'b0;
      chk_valid_d = 1'b0;
      chk_fail_d  = 1'b0;
      pass_d      = '0;
      fail_d      = '0;
      ill_d       = '0;
      ops_d       = '0;
      fv_d        = 1'b0;
      fa_d        = '0;
      fb_d        = '0;
      fc_d        = '0;
      fe_d        = '0;
      fs_d        = '0;
      halted_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_sel_q    <= '0;
      s1_exp_q    <= '0;
      chk_valid_q <= 1'b0;
      chk_fail_q  <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      ill_q       <= '0;
      ops_q       <= '0;
      fv_q        <= 1'b0;
      fa_q        <= '0;
      fb_q        <= '0;
      fc_q        <= '0;
      fe_q        <= '0;
      fs_q        <= '0;
      halted_q    <= 1'b0;
    end else begin
      rdy_en_q    <= 1'b1;
      s1_vld_q    <= s1_vld_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s1_sel_q    <= s1_sel_d;
      s1_exp_q    <= s1_exp_d;
      chk_valid_q <= chk_valid_d;
      chk_fail_q  <= chk_fail_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      ill_q       <= ill_d;
      ops_q       <= ops_d;
      fv_q        <= fv_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      fc_q        <= fc_d;
      fe_q        <= fe_d;
      fs_q        <= fs_d;
      halted_q    <= halted_d;
    end
  end

  assign chk_valid   = chk_valid_q;
  assign chk_fail    = chk_fail_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign illegal_cnt = ill_q;
  assign ops_seen    = ops_q;
  assign first_valid = fv_q;
  assign first_a     = fa_q;
  assign first_b     = fb_q;
  assign first_c     = fc_q;
  assign first_exp   = fe_q;
  assign first_sel   = fs_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: directed vectors, expected
// fail flags queued at accept and popped by a chk_valid monitor.
module tb_alu_result_checker;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0, in_c = '0;
  logic [3:0]    in_sel = '0;
  logic          chk_valid, chk_fail;
  logic [CW-1:0] pass_cnt, fail_cnt, illegal_cnt;
  logic [15:0]   ops_seen;
  logic          first_valid, halted;
  logic [W-1:0]  first_a, first_b, first_c, first_exp;
  logic [3:0]    first_sel;

  int tests = 0;
  int fails = 0;
  bit sb[$];
  bit acc;
  bit accs[5];

  alu_result_checker #(.WIDTH(W), .CNT_W(CW), .HALT_ON_FAIL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_c(in_c),
    .chk_valid(chk_valid), .chk_fail(chk_fail),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .illegal_cnt(illegal_cnt), .ops_seen(ops_seen),
    .first_valid(first_valid), .first_a(first_a), .first_b(first_b),
    .first_c(first_c), .first_exp(first_exp), .first_sel(first_sel),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one drive attempt; pushes the expected fail flag only if accepted
  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic [7:0] c,
                       input bit ef, output bit ok);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_sel = sel; in_c = c;
    #1;
    ok = in_ready;
    if (ok) sb.push_back(ef);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got chk_valid=1 expected no pulse");
      end else begin
        chk("sb_chk_fail", chk_fail, sb.pop_front());
      end
    end
  end

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_chk_valid", chk_valid, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_first_valid", first_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("rel_in_ready", in_ready, 1);

    // passes and latency
    drive(8'h0F, 8'h01, 4'd0, 8'h10, 1'b0, acc);
    @(negedge clk);
    chk("lat_k", chk_valid, 0);
    @(negedge clk);
    chk("lat_k1", chk_valid, 1);
    drive(8'h0F, 8'h01, 4'd1, 8'h0E, 1'b0, acc);
    drive(8'h0F, 8'h01, 4'd2, 8'h01, 1'b0, acc);
    drive(8'h0F, 8'h01, 4'd5, 8'h00, 1'b0, acc);
    idle(3);
    chk("t1_pass", pass_cnt, 4);
    chk("t1_fail", fail_cnt, 0);
    chk("t1_ops", ops_seen, 16'h0027);
    chk("t1_ill", illegal_cnt, 0);

    // wrap-around arithmetic
    drive(8'hF0, 8'h0F, 4'd0, 8'hFF, 1'b0, acc);
    drive(8'h00, 8'h71, 4'd1, 8'h8F, 1'b0, acc);
    idle(3);
    chk("t2_pass", pass_cnt, 6);
    chk("t2_fail", fail_cnt, 0);

    // single failure and halt
    drive(8'h30, 8'h15, 4'd10, 8'h00, 1'b1, acc);
    idle(3);
    chk("t3_fail", fail_cnt, 1);
    chk("t3_pass", pass_cnt, 6);
    chk("t3_fv", first_valid, 1);
    chk("t3_fexp", first_exp, 8'h01);
    chk("t3_fsel", first_sel, 4'hA);
    chk("t3_fa", first_a, 8'h30);
    chk("t3_fb", first_b, 8'h15);
    chk("t3_fc", first_c, 8'h00);
    chk("t3_halted", halted, 1);
    chk("t3_ready", in_ready, 0);
    chk("t3_ops", ops_seen, 16'h0427);
    drive(8'h01, 8'h01, 4'd0, 8'h02, 1'b0, acc);
    chk("t3_blocked", acc, 0);
    do_clear();
    idle(1);
    chk("clr_pass", pass_cnt, 0);
    chk("clr_fail", fail_cnt, 0);
    chk("clr_ops", ops_seen, 0);
    chk("clr_fv", first_valid, 0);
    chk("clr_fexp", first_exp, 0);
    chk("clr_halted", halted, 0);
    chk("clr_ready", in_ready, 1);

    // back-to-back stream, 3rd fails, 4th already in flight
    drive(8'h01, 8'h02, 4'd3, 8'h03, 1'b0, accs[0]);
    drive(8'hFF, 8'h0F, 4'd4, 8'hF0, 1'b0, accs[1]);
    drive(8'h81, 8'h00, 4'd6, 8'h00, 1'b1, accs[2]);
    drive(8'h00, 8'h40, 4'd7, 8'h00, 1'b1, accs[3]);
    drive(8'h04, 8'h00, 4'd8, 8'h02, 1'b0, accs[4]);
    chk("t4_acc4", accs[3], 1);
    chk("t4_acc5", accs[4], 0);
    idle(3);
    chk("t4_pass", pass_cnt, 2);
    chk("t4_fail", fail_cnt, 2);
    chk("t4_fa", first_a, 8'h81);
    chk("t4_fsel", first_sel, 4'd6);
    chk("t4_fexp", first_exp, 8'h02);
    chk("t4_ops", ops_seen, 16'h00D8);
    do_clear();

    // illegal opcode
    drive(8'h12, 8'h34, 4'hC, 8'h00, 1'b0, acc);
    idle(3);
    chk("t5_pass", pass_cnt, 1);
    chk("t5_ill1", illegal_cnt, 1);
    drive(8'h12, 8'h34, 4'hC, 8'h05, 1'b1, acc);
    idle(3);
    chk("t5_fail", fail_cnt, 1);
    chk("t5_ill2", illegal_cnt, 2);
    chk("t5_ops", ops_seen, 16'h1000);
    chk("t5_fexp", first_exp, 8'h00);
    do_clear();

    // clear with in_valid while S1 holds an entry
    drive(8'h01, 8'h01, 4'd0, 8'h02, 1'b0, acc);
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("t6_clr_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    idle(3);
    chk("t6_clr_pass", pass_cnt, 0);
    chk("t6_clr_fail", fail_cnt, 0);

    // reset with S1 full
    drive(8'h01, 8'h01, 4'd0, 8'h02, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cv", chk_valid, 0);
    chk("t6_rst_ready", in_ready, 0);
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(3);
    chk("t6_rst_pass", pass_cnt, 0);
    chk("t6_rst_ready2", in_ready, 1);

    // saturation
    for (int i = 0; i < 17; i++)
      drive(8'hFF, 8'h3C, 4'd2, 8'h3C, 1'b0, acc);
    idle(3);
    chk("t7_sat", pass_cnt, 4'hF);
    chk("t7_fail", fail_cnt, 0);

    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
